wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on posedge clk.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
REQ-003 SHALL have ports: in_valid  input  1  execute-stage result presented.
REQ-004 SHALL have ports: in_ready  output  1  block accepts the presented result this cycle.
REQ-005 SHALL have ports: in_rd  input  5  destination register index.
REQ-006 SHALL have ports: in_wen  input  1  instruction writes a register.
REQ-007 SHALL have ports: in_is_load  input  1  result comes from memory rather than the ALU.
REQ-008 SHALL have ports: in_ld_size  input  2  0=byte, 1=half, 2=word, 3=double.
REQ-009 SHALL have ports: in_ld_unsigned  input  1  zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have ports: in_addr_low  input  3  load address bits [2:0].
REQ-011 SHALL have ports: in_alu_result  input  64  ALU result.
REQ-012 SHALL have ports: mem_rvalid  input  1  load data valid this cycle.
REQ-013 SHALL have ports: mem_rdata  input  64  aligned doubleword from memory.
REQ-014 SHALL have ports: RD  output  5  register-file write index.
REQ-015 SHALL have ports: RD_Back  output  64  register-file write data.
REQ-016 SHALL have ports: Enable_Control  output  1  register-file write enable.
REQ-017 SHALL have ports: busy  output  1  load outstanding.
REQ-018 SHALL have ports: pending_rd  output  5  rd of the outstanding load, 0 when not busy.
REQ-019 SHALL have ports: wb_err  output  1  sticky timeout flag; present only with WB_TIMEOUT_EN.

Function
REQ-020 SHALL use states IDLE, WAIT_MEM; in_ready=1 only in IDLE.
REQ-021 In IDLE, in_valid & ~in_is_load SHALL register RD=in_rd, RD_Back=in_alu_result, Enable_Control=in_wen&(in_rd!=0) on the next posedge (latency 1); stay IDLE.
REQ-022 Back-to-back non-load results SHALL be accepted every cycle with no bubble.
REQ-023 In IDLE, in_valid & in_is_load SHALL capture rd, wen, size, unsigned, addr_low; go WAIT_MEM; Enable_Control=0 next cycle.
REQ-024 In WAIT_MEM, busy=1 and pending_rd = captured rd; in_valid SHALL be ignored.
REQ-025 In WAIT_MEM on mem_rvalid, the block SHALL compute lane = mem_rdata >> (8*addr_low), truncate to size, extend to 64 bits per unsigned, register into RD_Back with Enable_Control=wen&(rd!=0) on the next posedge, return to IDLE.
REQ-026 Size 3 SHALL ignore addr_low (no shift); bytes shifted past bit 63 SHALL read as 0.
REQ-027 mem_rvalid in IDLE SHALL be ignored without side effect.
REQ-028 Enable_Control SHALL be a single-cycle pulse per committed write; RD and RD_Back SHALL hold their last values when Enable_Control=0.
REQ-029 rd==0 SHALL never assert Enable_Control.

Reset
REQ-030 rst==0 SHALL force state IDLE, RD=0, RD_Back=0, Enable_Control=0, busy=0, pending_rd=0, wb_err=0, timeout counter=0.
REQ-031 Reset during WAIT_MEM SHALL discard the outstanding load; a later mem_rvalid SHALL be ignored.

Configuration
REQ-032 Macro WB_TIMEOUT_EN defined: 8-bit counter clears on WAIT_MEM entry and increments each WAIT_MEM cycle without mem_rvalid; at 255 the block SHALL set wb_err, return to IDLE, and perform no write.
REQ-033 WB_TIMEOUT_EN undefined: no counter, no wb_err port; WAIT_MEM SHALL wait indefinitely.

Verification
REQ-034 ALU op: in_rd=5, in_alu_result=0x1234, in_wen=1 -> next cycle RD=5, RD_Back=0x1234, Enable_Control=1 for one cycle.
REQ-035 Signed byte load: addr_low=3, mem_rdata=0x00000000_80000000 -> RD_Back=0xFFFFFFFF_FFFFFF80; with unsigned=1 -> 0x80.
REQ-036 Word load: addr_low=4, size=2, mem_rdata=0x8765_4321_0000_0000, signed -> RD_Back=0xFFFFFFFF_87654321; busy=1 and in_ready=0 until mem_rvalid.
REQ-037 in_rd=0, in_wen=1, alu result 0xFF -> Enable_Control stays 0.
REQ-038 Load accepted, rst=0 for one cycle, then mem_rvalid=1 -> no write, busy=0.
REQ-039 With WB_TIMEOUT_EN: load accepted, no mem_rvalid for 255 cycles -> wb_err=1, state IDLE, in_ready=1, no write.

Source files
------------

// File: rtl/wb_unit_if.sv
// wb_unit_if -- execute-stage result handshake plus memory load-return bus
// for the writeback unit.
//   master : drives in_valid and the in_* result fields, mem_rvalid, mem_rdata;
//            receives in_ready
//   slave  : the writeback unit (consumes the fields, drives in_ready)
interface wb_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        in_is_load;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [2:0]  in_addr_low;
  logic [63:0] in_alu_result;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output in_valid, in_rd, in_wen, in_is_load, in_ld_size, in_ld_unsigned,
           in_addr_low, in_alu_result, mem_rvalid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_wen, in_is_load, in_ld_size, in_ld_unsigned,
           in_addr_low, in_alu_result, mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/wb_unit.sv
// wb_unit -- writeback stage. ALU results are written to the register file
// one cycle after acceptance; loads park in WAIT_MEM until the memory returns
// the aligned doubleword, which is lane-selected, truncated and extended.
//
// Ports:
//   clk            sole clock
//   rst            synchronous active-low reset
//   bus            wb_unit_if.slave (execute handshake + memory return)
//   RD, RD_Back    register-file write index / data (hold when not writing)
//   Enable_Control register-file write enable, one-cycle pulse per write
//   busy           a load is outstanding
//   pending_rd     rd of the outstanding load, 0 when idle
//   wb_err         sticky load-timeout flag (only with WB_TIMEOUT_EN)
//
// Build option: define WB_TIMEOUT_EN to abandon a load after 255 cycles
// without memory data and raise wb_err. Default build waits forever.
//
// state    | meaning
// IDLE     | accepting results; ALU results write back next cycle
// WAIT_MEM | load outstanding, in_valid ignored, waiting for mem_rvalid
module wb_unit (
  input  logic        clk,
  input  logic        rst,
  wb_unit_if.slave    bus,
  output logic [4:0]  RD,
  output logic [63:0] RD_Back,
  output logic        Enable_Control,
  output logic        busy,
  output logic [4:0]  pending_rd
`ifdef WB_TIMEOUT_EN
  ,
  output logic        wb_err
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state;
  logic        in_ready_q;
  logic        ld_wen;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [2:0]  ld_addr;
  logic [63:0] lane;
  logic [63:0] ld_val;
`ifdef WB_TIMEOUT_EN
  logic [7:0]  tmo_cnt;
`endif

  assign bus.in_ready = in_ready_q;

  // Doubleword loads ignore addr_low; narrower loads shift their lane down,
  // and bytes beyond bit 63 fill with zero by virtue of the logical shift.
  always_comb begin
    lane   = (ld_size == 2'd3) ? bus.mem_rdata : (bus.mem_rdata >> {ld_addr, 3'b000});
    ld_val = '0;
    case (ld_size)
      2'd0: ld_val = ld_uns ? {56'b0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'd1: ld_val = ld_uns ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'd2: ld_val = ld_uns ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      2'd3: ld_val = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      in_ready_q     <= 1'b1;
      RD             <= '0;
      RD_Back        <= '0;
      Enable_Control <= 1'b0;
      busy           <= 1'b0;
      pending_rd     <= '0;
      ld_wen         <= 1'b0;
      ld_size        <= '0;
      ld_uns         <= 1'b0;
      ld_addr        <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_cnt        <= '0;
      wb_err         <= 1'b0;
`endif
    end else begin
      Enable_Control <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (!bus.in_is_load) begin
              RD             <= bus.in_rd;
              RD_Back        <= bus.in_alu_result;
              Enable_Control <= bus.in_wen & (bus.in_rd != 5'd0);
            end else begin
              state      <= WAIT_MEM;
              in_ready_q <= 1'b0;
              busy       <= 1'b1;
              pending_rd <= bus.in_rd;
              ld_wen     <= bus.in_wen;
              ld_size    <= bus.in_ld_size;
              ld_uns     <= bus.in_ld_unsigned;
              ld_addr    <= bus.in_addr_low;
`ifdef WB_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            RD             <= pending_rd;
            RD_Back        <= ld_val;
            Enable_Control <= ld_wen & (pending_rd != 5'd0);
            state          <= IDLE;
            in_ready_q     <= 1'b1;
            busy           <= 1'b0;
            pending_rd     <= '0;
          end
`ifdef WB_TIMEOUT_EN
          // The 255th consecutive empty cycle abandons the load.
          else if (tmo_cnt == 8'd254) begin
            tmo_cnt    <= 8'd255;
            wb_err     <= 1'b1;
            state      <= IDLE;
            in_ready_q <= 1'b1;
            busy       <= 1'b0;
            pending_rd <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  RD;
  logic [63:0] RD_Back;
  logic        Enable_Control;
  logic        busy;
  logic [4:0]  pending_rd;
`ifdef WB_TIMEOUT_EN
  logic        wb_err;
`endif

  wb_unit_if bus ();

  wb_unit dut (
    .clk(clk), .rst(rst), .bus(bus),
    .RD(RD), .RD_Back(RD_Back), .Enable_Control(Enable_Control),
    .busy(busy), .pending_rd(pending_rd)
`ifdef WB_TIMEOUT_EN
    , .wb_err(wb_err)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference load formatting: gather the selected bytes one at a time,
  // then fill upward from the top byte's sign bit.
  function automatic logic [63:0] load_value(input logic [1:0] sz, input logic uns,
                                             input logic [2:0] al, input logic [63:0] d);
    int n = 1 << sz;
    int base = (sz == 2'd3) ? 0 : int'(al);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) begin
      int idx = base + i;
      v[i*8 +: 8] = (idx < 8) ? d[idx*8 +: 8] : 8'h00;
    end
    if (!uns && v[n*8-1])
      for (int i = n*8; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Behavioural model
  bit          m_live = 0;
  bit          m_busy = 0;
  logic [4:0]  m_prd = '0;
  bit          m_wen = 0;
  logic [1:0]  m_sz = '0;
  bit          m_uns = 0;
  logic [2:0]  m_al = '0;
  int          m_wait = 0;
  bit          m_err = 0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0;
  bit          m_en = 0;

  always @(posedge clk) begin
    m_en = 0;
    if (!rst) begin
      m_busy = 0; m_prd = '0; m_err = 0; m_rd = '0; m_data = '0; m_wait = 0;
      m_live = 1;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        if (!bus.in_is_load) begin
          m_rd   = bus.in_rd;
          m_data = bus.in_alu_result;
          m_en   = bus.in_wen && (bus.in_rd != 0);
        end else begin
          m_busy = 1; m_prd = bus.in_rd; m_wen = bus.in_wen;
          m_sz = bus.in_ld_size; m_uns = bus.in_ld_unsigned; m_al = bus.in_addr_low;
          m_wait = 0;
        end
      end
    end else if (bus.mem_rvalid) begin
      m_rd   = m_prd;
      m_data = load_value(m_sz, m_uns, m_al, bus.mem_rdata);
      m_en   = m_wen && (m_prd != 0);
      m_busy = 0;
    end else begin
`ifdef WB_TIMEOUT_EN
      m_wait++;
      if (m_wait == 255) begin
        m_err  = 1;
        m_busy = 0;
      end
`endif
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready",   {63'b0, bus.in_ready},     {63'b0, !m_busy});
      chk("busy",       {63'b0, busy},             {63'b0, m_busy});
      chk("pending_rd", {59'b0, pending_rd},       {59'b0, (m_busy ? m_prd : 5'd0)});
      chk("wen",        {63'b0, Enable_Control},   {63'b0, m_en});
      chk("RD",         {59'b0, RD},               {59'b0, m_rd});
      chk("RD_Back",    RD_Back,                   m_data);
`ifdef WB_TIMEOUT_EN
      chk("wb_err",     {63'b0, wb_err},           {63'b0, m_err});
`endif
    end
  end

  task automatic idle_inputs();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_rd = 5'($urandom);
    bus.in_wen = 1'($urandom);
    bus.in_is_load = 1'($urandom);
    bus.in_ld_size = 2'($urandom);
    bus.in_ld_unsigned = 1'($urandom);
    bus.in_addr_low = 3'($urandom);
    bus.in_alu_result = {$urandom, $urandom};
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = {$urandom, $urandom};
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic wen, input logic [63:0] res);
    @(negedge clk); idle_inputs();
    bus.in_valid = 1'b1; bus.in_is_load = 1'b0;
    bus.in_rd = rd; bus.in_wen = wen; bus.in_alu_result = res;
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [1:0] sz,
                         input logic uns, input logic [2:0] al);
    @(negedge clk); idle_inputs();
    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_wen = 1'b1;
    bus.in_rd = rd; bus.in_ld_size = sz; bus.in_ld_unsigned = uns; bus.in_addr_low = al;
  endtask

  task automatic mem_ret(input logic [63:0] d);
    @(negedge clk); idle_inputs();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = d;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    // Pin the reference formatting itself.
    chk("model_sbyte", load_value(2'd0, 1'b0, 3'd3, 64'h00000000_80000000), 64'hFFFFFFFF_FFFFFF80);
    chk("model_ubyte", load_value(2'd0, 1'b1, 3'd3, 64'h00000000_80000000), 64'h80);
    chk("model_word",  load_value(2'd2, 1'b0, 3'd4, 64'h87654321_00000000), 64'hFFFFFFFF_87654321);
    chk("model_half_past_top", load_value(2'd1, 1'b0, 3'd7, 64'hAB000000_00000000), 64'h00AB);
    chk("model_dword_noshift", load_value(2'd3, 1'b0, 3'd5, 64'h80000000_00000001), 64'h80000000_00000001);

    repeat (2) @(posedge clk);
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    chk("rst_RD", {59'b0, RD}, 64'd0);
    chk("rst_RD_Back", RD_Back, 64'd0);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

    // ALU write, latency 1, single pulse
    alu_op(5'd5, 1'b1, 64'h1234);
    @(posedge clk); #1;
    chk("alu_RD", {59'b0, RD}, 64'd5);
    chk("alu_data", RD_Back, 64'h1234);
    chk("alu_en", {63'b0, Enable_Control}, 64'd1);
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    chk("alu_en_pulse", {63'b0, Enable_Control}, 64'd0);
    chk("alu_hold", RD_Back, 64'h1234);

    // rd==0 never writes
    alu_op(5'd0, 1'b1, 64'hFF);
    @(posedge clk); #1;
    chk("rd0_en", {63'b0, Enable_Control}, 64'd0);

    // Signed / unsigned byte loads
    for (int u = 0; u < 2; u++) begin
      load_op(5'd7, 2'd0, 1'(u), 3'd3);
      @(posedge clk); #1;
      chk("ld_busy", {63'b0, busy}, 64'd1);
      chk("ld_pending", {59'b0, pending_rd}, 64'd7);
      mem_ret(64'h00000000_80000000);
      @(posedge clk); #1;
      chk("ld_byte", RD_Back, (u == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h80);
      chk("ld_byte_en", {63'b0, Enable_Control}, 64'd1);
    end

    // Word load with in_valid ignored during the wait
    load_op(5'd9, 2'd2, 1'b0, 3'd4);
    alu_op(5'd3, 1'b1, 64'hDEAD);
    @(posedge clk); #1;
    chk("wait_in_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("wait_ignore", {63'b0, Enable_Control}, 64'd0);
    mem_ret(64'h87654321_00000000);
    @(posedge clk); #1;
    chk("ld_word", RD_Back, 64'hFFFFFFFF_87654321);
    chk("ld_word_rd", {59'b0, RD}, 64'd9);

    // Reset discards an outstanding load
    load_op(5'd12, 2'd3, 1'b0, 3'd0);
    @(negedge clk); idle_inputs(); rst = 1'b0;
    mem_ret(64'h1111_2222_3333_4444);
    @(posedge clk); #1;
    chk("rst_load_en", {63'b0, Enable_Control}, 64'd0);
    chk("rst_load_busy", {63'b0, busy}, 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); idle_inputs();
      rst = ($urandom_range(59) != 0);
      bus.in_valid = 1'($urandom);
      bus.in_is_load = ($urandom_range(2) == 0);
      if ($urandom_range(4) == 0) bus.in_rd = 5'd0;
      bus.mem_rvalid = ($urandom_range(2) == 0);
    end

`ifdef WB_TIMEOUT_EN
    @(negedge clk); idle_inputs(); rst = 1'b0;
    load_op(5'd4, 2'd2, 1'b0, 3'd0);
    repeat (254) begin @(negedge clk); idle_inputs(); end
    @(posedge clk); #1;
    chk("tmo_not_yet", {63'b0, wb_err}, 64'd0);
    chk("tmo_busy", {63'b0, busy}, 64'd1);
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    chk("tmo_err", {63'b0, wb_err}, 64'd1);
    chk("tmo_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("tmo_nowrite", {63'b0, Enable_Control}, 64'd0);
`endif

    @(negedge clk); idle_inputs();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
